wb_bus_arbiter: RTL
===================

Name: wb_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the system word bus.
- M0 is the CPU data port. M1 is the UART system controller (debug/load path).
- Grants the shared slave bus to one master per transaction, using round-robin on contention.
- Routes ack and rdata back to the granted master only, and terminates a transaction with an error ack when the slave never responds.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in a grant state without slave ack before a forced error ack; legal range 1..65535.
- ERR_WORD, 32'hDEAD_BEEF: rdata returned to the master on a timeout termination; truncated/extended to `WORD_SIZE.

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Rst  in  1  synchronous, active-low reset
- M0_wb_addr  in  `ADDR_SIZE  CPU address
- M0_wb_cs  in  1  CPU request; held until ack
- M0_wb_we  in  1  CPU write enable
- M0_wb_wdata  in  `WORD_SIZE  CPU write data
- M0_wb_rdata  out  `WORD_SIZE  read data to CPU
- M0_wb_ack  out  1  ack to CPU, one-cycle pulse
- M1_wb_addr  in  `ADDR_SIZE  UART ctrl address
- M1_wb_cs  in  1  UART ctrl request
- M1_wb_we  in  1  UART ctrl write enable
- M1_wb_wdata  in  `WORD_SIZE  UART ctrl write data
- M1_wb_rdata  out  `WORD_SIZE  read data to UART ctrl
- M1_wb_ack  out  1  ack to UART ctrl
- S_wb_addr  out  `ADDR_SIZE  slave address
- S_wb_cs  out  1  slave select
- S_wb_we  out  1  slave write enable
- S_wb_wdata  out  `WORD_SIZE  slave write data
- S_wb_rdata  in  `WORD_SIZE  slave read data
- S_wb_ack  in  1  slave ack
- Grant  out  2  one-hot current owner: bit0 = M0, bit1 = M1; 2'b00 when idle
- Bus_err  out  1  one-cycle pulse on timeout termination

Behaviour:
- Reset (Rst==0 at an edge):
  - state=IDLE, last_served=M1 (M0 wins the first tie), timeout counter=0.
  - All outputs 0, including Grant, S_wb_cs and Bus_err.
  - Reset mid-transaction: S_wb_cs low from the next cycle; no ack is issued.
- State machine: IDLE, GNT0, GNT1.
- IDLE:
  - If only M0_wb_cs → GNT0. If only M1_wb_cs → GNT1.
  - If both: grant the master that is not last_served.
  - If neither: stay in IDLE.
- GNTx:
  - S_wb_addr/we/wdata are combinationally muxed from master x.
  - S_wb_cs = Mx_wb_cs.
  - Grant is registered and equals the state.
- Latency: a request seen in IDLE at edge N drives S_wb_cs in cycle N+1. This is one cycle of arbitration latency.
- Ack routing:
  - Mx_wb_ack = S_wb_ack while in GNTx; the other master's ack is always 0.
  - Mx_wb_rdata = S_wb_rdata while in GNTx, else 0.
- Completion: on S_wb_ack in GNTx → IDLE, last_served=x, counter cleared. Masters must drop cs the cycle after ack.
- Back-to-back: a master always passes through one IDLE cycle. If both request in that IDLE cycle, the other master wins.
- Abort: Mx_wb_cs drops in GNTx without ack → IDLE, last_served=x, no ack, no Bus_err.
- Timeout:
  - The counter increments each cycle in GNTx with S_wb_ack=0.
  - When the counter == TIMEOUT_CYCLES-1 and there is still no ack, the arbiter issues for one cycle:
    - Mx_wb_ack=1
    - Mx_wb_rdata=ERR_WORD
    - Bus_err=1
    - S_wb_cs=0
  - Then → IDLE, last_served=x.
  - If the slave ack arrives in that same cycle, the real ack wins: normal completion, Bus_err=0.
- Signals in IDLE:
  - S_wb_* outputs are 0.
  - A slave ack seen in IDLE is ignored and not forwarded.
- Writes and reads are treated identically; the arbiter never modifies addr or data.

Test Plan:
- Single M0 read:
  - Stimulus: M0_wb_cs=1, addr=0x100, we=0; slave acks after 2 cycles with rdata=0x12345678.
  - Required: S_wb_cs rises 1 cycle after request; Grant=01; M0_wb_ack pulses with M0_wb_rdata=0x12345678; M1_wb_ack stays 0.
- Simultaneous requests after reset:
  - Stimulus: M0 and M1 both assert cs in the same cycle.
  - Required: M0 served first (Grant=01), then M1 (Grant=10) after one IDLE cycle.
  - Repeat the same stimulus: M1 is not served twice in a row, and the order alternates.
- M1 write:
  - Stimulus: M1 write, addr=0x2000, wdata=0xA5A5A5A5.
  - Required: S_wb_we=1 and S_wb_wdata=0xA5A5A5A5 while Grant=10; M1_wb_ack is a one-cycle pulse.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; slave never acks an M1 read.
  - Required: exactly 8 cycles after grant, M1_wb_ack=1, M1_wb_rdata=0xDEADBEEF, Bus_err=1 for 1 cycle, S_wb_cs=0; then IDLE.
  - Variant: slave ack arrives on cycle 8 → real data is returned, Bus_err=0.
- Abort and reset:
  - Stimulus: M0 drops cs mid-grant.
  - Required: returns to IDLE with no ack; M1 is granted next.
  - Stimulus: Rst=0 during GNT1.
  - Required: all outputs 0 the next cycle; after reset release, a tie goes to M0.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave word-bus arbiter: round-robin on contention, ack and
// rdata routed to the owner only, error termination when the slave goes silent.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module wb_bus_arbiter #(
  parameter int unsigned             TIMEOUT_CYCLES = 255,
  parameter logic [`WORD_SIZE-1:0]   ERR_WORD       = `WORD_SIZE'(32'hDEAD_BEEF)
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [`ADDR_SIZE-1:0]  M0_wb_addr,
  input  logic                   M0_wb_cs,
  input  logic                   M0_wb_we,
  input  logic [`WORD_SIZE-1:0]  M0_wb_wdata,
  output logic [`WORD_SIZE-1:0]  M0_wb_rdata,
  output logic                   M0_wb_ack,
  input  logic [`ADDR_SIZE-1:0]  M1_wb_addr,
  input  logic                   M1_wb_cs,
  input  logic                   M1_wb_we,
  input  logic [`WORD_SIZE-1:0]  M1_wb_wdata,
  output logic [`WORD_SIZE-1:0]  M1_wb_rdata,
  output logic                   M1_wb_ack,
  output logic [`ADDR_SIZE-1:0]  S_wb_addr,
  output logic                   S_wb_cs,
  output logic                   S_wb_we,
  output logic [`WORD_SIZE-1:0]  S_wb_wdata,
  input  logic [`WORD_SIZE-1:0]  S_wb_rdata,
  input  logic                   S_wb_ack,
  output logic [1:0]             Grant,
  output logic                   Bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;    // 0 = M0 served last, 1 = M1
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;

  logic                  busy, owner, req, timeout, ack;
  logic [`WORD_SIZE-1:0] rdata;

  assign busy  = (state_q == GNT0) || (state_q == GNT1);
  assign owner = (state_q == GNT1);
  assign req   = owner ? M1_wb_cs : M0_wb_cs;

  // A real slave ack in the last allowed cycle beats the forced error ack.
  assign timeout = busy && req && !S_wb_ack && (cnt_q == TO_LAST);
  assign ack     = busy && (S_wb_ack || timeout);
  assign rdata   = timeout ? ERR_WORD : S_wb_rdata;

  assign S_wb_cs    = busy && req && !timeout;
  assign S_wb_addr  = !busy ? '0 : (owner ? M1_wb_addr  : M0_wb_addr);
  assign S_wb_we    = busy && (owner ? M1_wb_we : M0_wb_we);
  assign S_wb_wdata = !busy ? '0 : (owner ? M1_wb_wdata : M0_wb_wdata);

  assign M0_wb_ack   = ack && !owner;
  assign M1_wb_ack   = ack &&  owner;
  assign M0_wb_rdata = (busy && !owner) ? rdata : '0;
  assign M1_wb_rdata = (busy &&  owner) ? rdata : '0;
  assign Bus_err     = timeout;
  assign Grant       = grant_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (M0_wb_cs && M1_wb_cs) state_d = last_q ? GNT0 : GNT1;
        else if (M0_wb_cs)        state_d = GNT0;
        else if (M1_wb_cs)        state_d = GNT1;
      end
      GNT0, GNT1: begin
        // Completion, abort and timeout all release the bus the same way.
        if (S_wb_ack || !req || timeout) begin
          state_d = IDLE;
          last_d  = owner;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    grant_d = {state_d == GNT1, state_d == GNT0};
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

endmodule
